// File: rtl/fast_frame_sequencer.sv
// fast_frame_sequencer: raster column sequencer for a FAST corner core.
// Walks the image in 7-row bands. Each band is read column by column.
// Load beats are tagged with their column so that core scores can be
// turned into corner coordinates. Corners are buffered in a 4-entry FIFO
// and leave through a valid/ready stream.
// Optional feature: define FAST_SEQ_OVF_CNT_EN to count dropped corners on
// ovf_cnt. When it is not defined, ovf_cnt is tied to zero.
module fast_frame_sequencer #(
  parameter int unsigned IMG_W    = 200,
  parameter int unsigned IMG_H    = 7,
  parameter int unsigned CORE_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] thresh,
  output logic        busy,
  output logic        done,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [55:0] mem_rdata,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [7:0]  data3,
  output logic [7:0]  data4,
  output logic [7:0]  data5,
  output logic [7:0]  data6,
  output logic [7:0]  data7,
  output logic        load,
  output logic        core_rst,
  input  logic [15:0] core_score,
  input  logic        core_en,
  output logic        corner_valid,
  input  logic        corner_ready,
  output logic [7:0]  corner_x,
  output logic [7:0]  corner_y,
  output logic [15:0] corner_score,
  output logic [15:0] ovf_cnt
);

  localparam logic [7:0] LastCol     = 8'(IMG_W - 1);
  localparam logic [7:0] LastRowBase = 8'(IMG_H - 7);
  localparam logic [3:0] DrainLast   = 4'(CORE_LAT);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StNext, StDone} state_e;

  state_e      state_q;
  logic        busy_q, done_q, mem_rd_q, core_rst_q, load_q;
  logic [7:0]  row_base_q, col_q, load_tag_q;
  logic [3:0]  drain_cnt_q;
  logic [15:0] thresh_q;
  logic [7:0]  tag_pipe_q [CORE_LAT];
  logic        start_acc;

  assign start_acc = start && (state_q == StIdle);

  // Frame FSM: band/column walk with registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      core_rst_q  <= 1'b1;
      row_base_q  <= 8'd0;
      col_q       <= 8'd0;
      drain_cnt_q <= 4'd0;
      thresh_q    <= 16'd0;
    end else begin
      done_q     <= 1'b0;
      core_rst_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_acc) begin
            state_q    <= StFetch;
            busy_q     <= 1'b1;
            mem_rd_q   <= 1'b1;
            row_base_q <= 8'd0;
            col_q      <= 8'd0;
            thresh_q   <= thresh;
          end
        end
        StFetch: begin
          if (col_q == LastCol) begin
            state_q     <= StDrain;
            mem_rd_q    <= 1'b0;
            drain_cnt_q <= 4'd0;
          end else begin
            col_q <= col_q + 8'd1;
          end
        end
        StDrain: begin
          // Wait for the last beat's score to leave the core
          if (drain_cnt_q == DrainLast) begin
            state_q    <= StNext;
            core_rst_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 4'd1;
          end
        end
        StNext: begin
          if (row_base_q == LastRowBase) begin
            state_q <= StDone;
          end else begin
            state_q    <= StFetch;
            row_base_q <= row_base_q + 8'd1;
            col_q      <= 8'd0;
            mem_rd_q   <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Load strobe and column tag delay line, aligned with core_en
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q     <= 1'b0;
      load_tag_q <= 8'd0;
      for (int unsigned i = 0; i < CORE_LAT; i++) begin
        tag_pipe_q[i] <= 8'd0;
      end
    end else begin
      load_q <= mem_rd_q;
      if (mem_rd_q) begin
        load_tag_q <= col_q;
      end
      tag_pipe_q[0] <= load_tag_q;
      for (int unsigned i = 1; i < CORE_LAT; i++) begin
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = {row_base_q, col_q};
  assign load     = load_q;
  assign core_rst = core_rst_q;

  assign data1 = mem_rdata[7:0];
  assign data2 = mem_rdata[15:8];
  assign data3 = mem_rdata[23:16];
  assign data4 = mem_rdata[31:24];
  assign data5 = mem_rdata[39:32];
  assign data6 = mem_rdata[47:40];
  assign data7 = mem_rdata[55:48];

  // Corner candidate: the 3-pixel ring needs at least 6 columns of history
  logic [7:0]  cand_tag;
  logic        cand;
  logic [31:0] cand_entry;

  assign cand_tag   = tag_pipe_q[CORE_LAT-1];
  assign cand       = core_en && (cand_tag >= 8'd6) && (core_score > thresh_q);
  assign cand_entry = {cand_tag - 8'd3, row_base_q + 8'd3, core_score};

  logic [31:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        fifo_full, pop, push;

  assign fifo_full = (count_q == 3'd4);
  assign pop       = corner_valid && corner_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push      = cand && (!fifo_full || pop);

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cand_entry;
    end
  end

  assign corner_valid = (count_q != 3'd0);
  assign corner_x     = fifo_q[rd_ptr_q][31:24];
  assign corner_y     = fifo_q[rd_ptr_q][23:16];
  assign corner_score = fifo_q[rd_ptr_q][15:0];

`ifdef FAST_SEQ_OVF_CNT_EN
  logic [15:0] ovf_q;
  logic        drop;

  assign drop = cand && fifo_full && !pop;

  // Saturating drop counter, restarted with each accepted frame
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 16'd0;
    end else if (start_acc) begin
      ovf_q <= 16'd0;
    end else if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Bench for fast_frame_sequencer: one 200x7 instance with a table-driven
// core stand-in, plus a 10x9 instance for multi-band sequencing.
module tb_fast_frame_sequencer;
  localparam int W    = 200;
  localparam int LAT  = 2;
  localparam int BW   = 10;
  localparam int BLAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A signals
  logic        reset = 1'b1, start = 1'b0, corner_ready = 1'b1;
  logic [15:0] thresh = 16'd0;
  logic        busy, done, mem_rd, load, core_rst, corner_valid;
  logic        core_en = 1'b0;
  logic [15:0] core_score = 16'd0;
  logic [15:0] mem_addr, corner_score, ovf_cnt;
  logic [55:0] mem_rdata = 56'd0;
  logic [7:0]  d [7];
  logic [7:0]  corner_x, corner_y;

  // Instance B signals
  logic        b_start = 1'b0;
  logic        b_corner_ready = 1'b1;
  logic [15:0] b_thresh = 16'd100;
  logic [15:0] b_core_score = 16'd300;
  logic        b_core_en = 1'b0;
  logic [55:0] b_mem_rdata = 56'd0;
  logic        b_busy, b_done, b_mem_rd, b_load, b_core_rst, b_corner_valid;
  logic [15:0] b_mem_addr, b_corner_score, b_ovf;
  logic [7:0]  b_d [7];
  logic [7:0]  b_corner_x, b_corner_y;

  fast_frame_sequencer #(.IMG_W(W), .IMG_H(7), .CORE_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .thresh(thresh), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data1(d[0]), .data2(d[1]), .data3(d[2]), .data4(d[3]), .data5(d[4]), .data6(d[5]),
    .data7(d[6]), .load(load), .core_rst(core_rst), .core_score(core_score),
    .core_en(core_en), .corner_valid(corner_valid), .corner_ready(corner_ready),
    .corner_x(corner_x), .corner_y(corner_y), .corner_score(corner_score), .ovf_cnt(ovf_cnt)
  );

  fast_frame_sequencer #(.IMG_W(BW), .IMG_H(9), .CORE_LAT(BLAT)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .thresh(b_thresh), .busy(b_busy),
    .done(b_done), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .data1(b_d[0]), .data2(b_d[1]), .data3(b_d[2]), .data4(b_d[3]), .data5(b_d[4]),
    .data6(b_d[5]), .data7(b_d[6]), .load(b_load), .core_rst(b_core_rst),
    .core_score(b_core_score), .core_en(b_core_en), .corner_valid(b_corner_valid),
    .corner_ready(b_corner_ready), .corner_x(b_corner_x), .corner_y(b_corner_y),
    .corner_score(b_corner_score), .ovf_cnt(b_ovf)
  );

  // Core stand-in for A: per-column score table, answer LAT cycles after each load beat
  bit          en_tab [256];
  logic [15:0] sc_tab [256];
  bit          h_en [LAT+1];
  logic [15:0] h_sc [LAT+1];
  int          a_beat = 0;

  always @(negedge clk) begin
    if (!busy) a_beat = 0;
    for (int i = LAT; i > 0; i--) begin
      h_en[i] = h_en[i-1];
      h_sc[i] = h_sc[i-1];
    end
    if (load && busy && a_beat < 256) begin
      h_en[0] = en_tab[a_beat];
      h_sc[0] = sc_tab[a_beat];
      a_beat++;
    end else begin
      h_en[0] = 1'b0;
      h_sc[0] = 16'd0;
    end
    core_en    = h_en[LAT];
    core_score = h_sc[LAT];
  end

  // Core stand-in for B: every beat scores 300
  bit bh [BLAT+1];
  always @(negedge clk) begin
    for (int i = BLAT; i > 0; i--) bh[i] = bh[i-1];
    bh[0]     = b_load;
    b_core_en = bh[BLAT];
  end

  logic [31:0] got [$];
  always begin
    @(negedge clk);
    #1;
    if (corner_valid && corner_ready) got.push_back({corner_x, corner_y, corner_score});
  end

  int          b_beats = 0, b_rst_pulses = 0, b_dones = 0;
  logic [7:0]  b_rows [$];
  logic [31:0] b_got [$];
  always begin
    @(negedge clk);
    #1;
    if (b_mem_rd) begin
      b_beats++;
      if (b_mem_addr[7:0] == 8'd0) b_rows.push_back(b_mem_addr[15:8]);
    end
    if (b_core_rst && b_busy) b_rst_pulses++;
    if (b_done) b_dones++;
    if (b_corner_valid && b_corner_ready)
      b_got.push_back({b_corner_x, b_corner_y, b_corner_score});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_q [$];

  task automatic clear_tab();
    for (int i = 0; i < 256; i++) begin
      en_tab[i] = 1'b0;
      sc_tab[i] = 16'd0;
    end
  endtask

  // Reference: every enabled column with enough history and a score strictly above threshold
  task automatic build_exp(input logic [15:0] thr);
    exp_q.delete();
    for (int c = 6; c < W; c++)
      if (en_tab[c] && sc_tab[c] > thr) exp_q.push_back({8'(c - 3), 8'd3, sc_tab[c]});
  endtask

  task automatic cmp_corners(input string tag, input int n);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < n && i < got.size() && i < exp_q.size(); i++)
      check(tag, got[i], exp_q[i]);
  endtask

  // One frame on A: address sequence, load lag, done latency; optional stray start
  task automatic run_frame(input int inject_col);
    int beats, first, done_t, dones;
    bit prev_rd;
    beats = 0; first = -1; done_t = -1; dones = 0; prev_rd = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < 600; t++) begin
      check("load_lag", load, prev_rd);
      if (mem_rd) begin
        if (first < 0) first = t;
        check("mem_addr", mem_addr, 32'(beats));
        beats++;
      end
      if (done) begin
        dones++;
        if (done_t < 0) done_t = t;
      end
      prev_rd = mem_rd;
      if (done_t >= 0 && t >= done_t + 3) break;
      start = (inject_col >= 0 && mem_rd && int'(mem_addr[7:0]) == inject_col);
      @(negedge clk);
    end
    start = 1'b0;
    check("rd_beats", beats, W);
    check("first_rd", first, 0);
    check("done_lat", done_t - first, W + LAT + 3);
    check("done_pulses", dones, 1);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    int found, dcount;
    logic [55:0] rv;
    logic [15:0] thr;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_load", load, 1'b0);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_valid", corner_valid, 1'b0);
    check("rst_ovf", ovf_cnt, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("core_rst_release", core_rst, 1'b0);

    // Row streams are byte slices of mem_rdata
    rv = {24'($urandom), $urandom};
    mem_rdata = rv;
    #1;
    for (int i = 0; i < 7; i++) check("data_byte", d[i], rv[8*i +: 8]);

    // Directed thresholds plus the 9-row instance in parallel
    clear_tab();
    en_tab[10] = 1'b1; sc_tab[10] = 16'd101;
    en_tab[11] = 1'b1; sc_tab[11] = 16'd100;
    en_tab[4]  = 1'b1; sc_tab[4]  = 16'd500;
    thresh = 16'd100;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    run_frame(-1);
    repeat (8) @(negedge clk);
    build_exp(16'd100);
    cmp_corners("thr_corner", 4);
    if (got.size() > 0) check("thr_corner_abs", got[0], {8'd7, 8'd3, 16'd101});
    else check("thr_corner_abs", 32'd0, {8'd7, 8'd3, 16'd101});

    check("b_beats", b_beats, 3 * BW);
    check("b_rows_n", b_rows.size(), 3);
    for (int i = 0; i < 3 && i < b_rows.size(); i++) check("b_row_base", b_rows[i], i);
    check("b_core_rst", b_rst_pulses, 3);
    check("b_done", b_dones, 1);
    check("b_corner_count", b_got.size(), 12);
    for (int r = 0; r < 3; r++)
      for (int c = 6; c < BW; c++)
        if (r * 4 + c - 6 < b_got.size())
          check("b_corner", b_got[r * 4 + c - 6], {8'(c - 3), 8'(r + 3), 16'd300});

    // Random scores, with a stray start injected mid-fetch
    clear_tab();
    for (int c = 0; c < W; c++) begin
      en_tab[c] = ($urandom_range(0, 3) == 0);
      sc_tab[c] = 16'($urandom_range(0, 2000));
    end
    thr = 16'($urandom_range(0, 1500));
    thresh = thr;
    got.delete();
    run_frame(77);
    repeat (8) @(negedge clk);
    build_exp(thr);
    cmp_corners("rand_corner", 64);

    // Back-pressure: six candidates against a 4-deep FIFO
    clear_tab();
    for (int c = 20; c < 26; c++) begin
      en_tab[c] = 1'b1;
      sc_tab[c] = 16'(180 + c);
    end
    thresh = 16'd100;
    corner_ready = 1'b0;
    got.delete();
    run_frame(-1);
    check("bp_popped", got.size(), 0);
    check("bp_valid", corner_valid, 1'b1);
`ifdef FAST_SEQ_OVF_CNT_EN
    check("bp_ovf", ovf_cnt, 16'd2);
`else
    check("bp_ovf", ovf_cnt, 16'd0);
`endif
    corner_ready = 1'b1;
    repeat (10) @(negedge clk);
    build_exp(16'd100);
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_corner", got[i], exp_q[i]);

    // Reset in the middle of a frame with corners queued
    clear_tab();
    for (int c = 10; c < 16; c++) begin
      en_tab[c] = 1'b1;
      sc_tab[c] = 16'd500;
    end
    corner_ready = 1'b0;
    got.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int t = 0; t < 300 && found == 0; t++) begin
      if (mem_rd && mem_addr[7:0] == 8'd50) found = 1;
      else @(negedge clk);
    end
    check("abort_reached", found, 1);
    check("abort_pre_valid", corner_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_mem_rd", mem_rd, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", corner_valid, 1'b0);
    check("abort_core_rst", core_rst, 1'b1);
    check("abort_ovf", ovf_cnt, 16'd0);
    dcount = 0;
    for (int t = 0; t < 250; t++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    clear_tab();
    corner_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_discarded", got.size(), 0);
    run_frame(-1);
    repeat (8) @(negedge clk);
    check("restart_corners", got.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
